// File: rtl/wave_pwm_dac.sv
// wave_pwm_dac
// Converts a WAVE_WIDTH-bit waveform sample into a 1-bit PWM stream for an
// external RC-filtered DAC. The duty is double-buffered: one sample is taken
// per PWM period, on the reload edge only, so the duty never changes
// mid-period. Dropping enable lets the current period finish (DRAIN) before
// the block goes idle; raising it again in DRAIN resumes without a gap.
//
// Optional feature (macro PWM_CENTER_ALIGNED_EN):
//   defined   - centre-aligned PWM. The counter runs up 0..P-1, then down
//               P-1..0 (2P cycles). pwm_out = (cnt >= P - duty), which gives
//               2*duty high cycles centred on the up/down turn. Reload and
//               idle exit happen at the end of the down phase.
//   undefined - edge-aligned PWM, P-cycle period, pwm_out = (cnt < duty).
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_in       in   synchronous active-high reset
//   enable       in   run request
//   wave_in      in   [WAVE_WIDTH] sample from the waveform generator
//   pwm_out      out  registered PWM stream
//   period_start out  one-cycle pulse in the first cycle of each period
//   duty_q       out  [PWM_BITS] duty currently applied
//   active       out  high in RUN or DRAIN
module wave_pwm_dac #(
    parameter int WAVE_WIDTH = 16,
    parameter int PWM_BITS   = 8,
    parameter int SIGNED_IN  = 1
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  enable,
    input  logic [WAVE_WIDTH-1:0] wave_in,
    output logic                  pwm_out,
    output logic                  period_start,
    output logic [PWM_BITS-1:0]   duty_q,
    output logic                  active
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // P = 2^PWM_BITS - 1; the counter tops out at P-1.
    localparam logic [PWM_BITS-1:0] P    = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] P_M1 = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS-1:0] ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [PWM_BITS-1:0] ZERO = '0;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_d;
    logic                pwm_out_q, pwm_out_d;
    logic                period_start_q, period_start_d;
    logic                active_q, active_d;
    logic [PWM_BITS-1:0] duty_conv;
    logic                period_end;

`ifdef PWM_CENTER_ALIGNED_EN
    logic dir_q, dir_d;   // 0 = counting up, 1 = counting down
`endif

    // Lower sample bits are below the PWM resolution and deliberately dropped.
    generate
        if (PWM_BITS < WAVE_WIDTH) begin : g_unused
            logic unused_low;
            assign unused_low = ^wave_in[WAVE_WIDTH-PWM_BITS-1:0];
        end
    endgenerate

    // Top PWM_BITS of the sample; flipping the MSB maps two's complement to
    // offset binary so mid-scale (0) lands at half duty.
    always_comb begin
        duty_conv = wave_in[WAVE_WIDTH-1 -: PWM_BITS];
        if (SIGNED_IN != 0)
            duty_conv[PWM_BITS-1] = ~duty_conv[PWM_BITS-1];
    end

`ifdef PWM_CENTER_ALIGNED_EN
    assign period_end = dir_q && (cnt_q == ZERO);
`else
    assign period_end = (cnt_q == P_M1);
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        duty_d         = duty_q;
        period_start_d = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
        dir_d          = dir_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = ZERO;
`ifdef PWM_CENTER_ALIGNED_EN
                dir_d = 1'b0;
`endif
                if (enable) begin
                    state_d        = RUN;
                    duty_d         = duty_conv;
                    period_start_d = 1'b1;
                end
            end
            default: begin  // RUN and DRAIN count identically
                if (period_end) begin
                    cnt_d = ZERO;
`ifdef PWM_CENTER_ALIGNED_EN
                    dir_d = 1'b0;
`endif
                    // A wrap with enable low ends the run, even from RUN.
                    if (enable) begin
                        state_d        = RUN;
                        duty_d         = duty_conv;
                        period_start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = enable ? RUN : DRAIN;
`ifdef PWM_CENTER_ALIGNED_EN
                    // P-1 is held for two cycles: last of up, first of down.
                    if (!dir_q) begin
                        if (cnt_q == P_M1) dir_d = 1'b1;
                        else               cnt_d = cnt_q + ONE;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
`else
                    cnt_d = cnt_q + ONE;
`endif
                end
            end
        endcase

        active_d = (state_d != IDLE);
        // Compare against next-cycle count/duty so the registered output lines
        // up with the counter value of the same cycle.
`ifdef PWM_CENTER_ALIGNED_EN
        pwm_out_d = active_d && (cnt_d >= (P - duty_d));
`else
        pwm_out_d = active_d && (cnt_d < duty_d);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q        <= IDLE;
            cnt_q          <= ZERO;
            duty_q         <= ZERO;
            pwm_out_q      <= 1'b0;
            period_start_q <= 1'b0;
            active_q       <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
            active_q       <= active_d;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_q          <= dir_d;
`endif
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;
    assign active       = active_q;

endmodule

// File: tb/tb_wave_pwm_dac.sv
module tb_wave_pwm_dac;

`ifdef PWM_CENTER_ALIGNED_EN
    localparam int  PER    = 30;
    localparam bit  CENTER = 1'b1;
`else
    localparam int  PER    = 15;
    localparam bit  CENTER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_in;
    logic        enable;
    logic [15:0] wave_in;
    logic        pwm_out, period_start, active;
    logic [3:0]  duty_q;
    logic        pwm_u, ps_u, active_u;
    logic [3:0]  duty_u;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    wave_pwm_dac #(.WAVE_WIDTH(16), .PWM_BITS(4), .SIGNED_IN(1)) u_dut (
        .clk(clk), .rst_in(rst_in), .enable(enable), .wave_in(wave_in),
        .pwm_out(pwm_out), .period_start(period_start), .duty_q(duty_q),
        .active(active)
    );

    wave_pwm_dac #(.WAVE_WIDTH(16), .PWM_BITS(4), .SIGNED_IN(0)) u_dut_u (
        .clk(clk), .rst_in(rst_in), .enable(enable), .wave_in(wave_in),
        .pwm_out(pwm_u), .period_start(ps_u), .duty_q(duty_u),
        .active(active_u)
    );

    typedef struct {
        logic [15:0] wave;
        int          ds;       // signed duty
        int          du;       // unsigned duty
        int          hi_e;     // high cycles per period, edge-aligned
        int          first_e;  // first high cycle index, edge-aligned
        int          hi_c;     // high cycles per period, centre-aligned
        int          first_c;  // first high cycle index, centre-aligned
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then enable with sample w; returns in cycle 0 of the first period.
    task automatic start(input logic [15:0] w);
        rst_in  = 1'b1;
        enable  = 1'b0;
        tick();
        rst_in  = 1'b0;
        wave_in = w;
        enable  = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int hi, first, psn, bad;

        vecs[0] = '{16'h0000,  8,  0,  8,  0, 16,  7};
        vecs[1] = '{16'h7FFF, 15,  7, 15,  0, 30,  0};
        vecs[2] = '{16'h8000,  0,  8,  0, -1,  0, -1};
        vecs[3] = '{16'h4000, 12,  4, 12,  0, 24,  3};
        vecs[4] = '{16'hC000,  4, 12,  4,  0,  8, 11};
        vecs[5] = '{16'hFFFF,  7, 15,  7,  0, 14,  8};

        // Reset held with enable high
        rst_in = 1'b1; enable = 1'b1; wave_in = 16'h0000;
        repeat (3) tick();
        check("rst_pwm",    int'(pwm_out), 0);
        check("rst_ps",     int'(period_start), 0);
        check("rst_active", int'(active), 0);
        check("rst_duty",   int'(duty_q), 0);
        rst_in = 1'b0;
        tick();
        check("rel_ps",     int'(period_start), 1);
        check("rel_active", int'(active), 1);
        tick();
        check("rel_ps_pulse", int'(period_start), 0);

        // Table: duty conversion and per-period waveform
        for (int v = 0; v < 6; v++) begin
            start(vecs[v].wave);
            check($sformatf("v%0d_duty_s", v), int'(duty_q), vecs[v].ds);
            check($sformatf("v%0d_duty_u", v), int'(duty_u), vecs[v].du);
            hi = 0; first = -1; psn = 0;
            for (int i = 0; i < PER; i++) begin
                if (pwm_out) begin
                    hi++;
                    if (first < 0) first = i;
                end
                if (period_start) psn++;
                if (i < PER - 1) tick();
            end
            check($sformatf("v%0d_high", v),  hi,    CENTER ? vecs[v].hi_c : vecs[v].hi_e);
            check($sformatf("v%0d_first", v), first, CENTER ? vecs[v].first_c : vecs[v].first_e);
            check($sformatf("v%0d_psn", v),   psn,   1);
            tick();
            check($sformatf("v%0d_wrap_ps", v), int'(period_start), 1);
        end

        // Sample change mid-period is ignored until the next reload
        start(16'h0000);
        repeat (3) tick();
        wave_in = 16'h4000;
        bad = 0;
        for (int i = 3; i < PER; i++) begin
            if (duty_q != 4'd8) bad++;
            if (i < PER - 1) tick();
        end
        check("hold_duty_bad", bad, 0);
        tick();
        check("reload_ps",   int'(period_start), 1);
        check("reload_duty", int'(duty_q), 12);

        // Enable dropped at cnt=5: finish period, then idle
        start(16'h0000);
        hi = 0; bad = 0;
        for (int i = 0; i < PER; i++) begin
            if (pwm_out) hi++;
            if (!active) bad++;
            if (i == 5) enable = 1'b0;
            if (i < PER - 1) tick();
        end
        check("drain_high",     hi, CENTER ? 16 : 8);
        check("drain_inactive", bad, 0);
        tick();
        check("drain_exit_active", int'(active), 0);
        check("drain_exit_pwm",    int'(pwm_out), 0);
        check("drain_exit_ps",     int'(period_start), 0);
        bad = 0;
        repeat (PER) begin
            tick();
            if (pwm_out || active || period_start) bad++;
        end
        check("idle_quiet", bad, 0);

        // Enable re-raised at cnt=9 while draining: seamless next period
        start(16'h0000);
        bad = 0;
        for (int i = 0; i < PER; i++) begin
            if (!active) bad++;
            if (i == 5) enable = 1'b0;
            if (i == 9) begin
                enable  = 1'b1;
                wave_in = 16'h4000;
            end
            if (i < PER - 1) tick();
        end
        check("rearm_inactive", bad, 0);
        tick();
        check("rearm_ps",     int'(period_start), 1);
        check("rearm_active", int'(active), 1);
        check("rearm_duty",   int'(duty_q), 12);

        // Reset mid-period while pwm_out is high
        start(16'h0000);
        repeat (7) tick();
        check("mid_pwm_hi", int'(pwm_out), 1);
        rst_in = 1'b1;
        tick();
        check("mid_rst_pwm",    int'(pwm_out), 0);
        check("mid_rst_active", int'(active), 0);
        check("mid_rst_duty",   int'(duty_q), 0);
        rst_in = 1'b0;
        tick();
        check("mid_rst_restart_ps", int'(period_start), 1);
        check("mid_rst_restart_pwm", int'(pwm_out), CENTER ? 0 : 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
